// File: rtl/falafel_resp_router.sv
// Pairs in-order core responses with pending message IDs and steers each tagged
// response into one of NUM_CHANNELS independent per-requester output FIFOs.
module falafel_resp_router #(
  parameter int DATA_W       = 64,
  parameter int MSG_ID_SIZE  = 8,
  parameter int NUM_CHANNELS = 2,
  parameter int CHAN_DEPTH   = 4,
  parameter int TAG_DEPTH    = 8
) (
  input  logic                                     clk_i,
  input  logic                                     rst_ni,
  input  logic                                     flush_i,
  input  logic                                     tag_val_i,
  output logic                                     tag_rdy_o,
  input  logic [MSG_ID_SIZE-1:0]                   tag_id_i,
  input  logic                                     in_val_i,
  output logic                                     in_rdy_o,
  input  logic [DATA_W-1:0]                        in_data_i,
  output logic [NUM_CHANNELS-1:0]                  out_val_o,
  input  logic [NUM_CHANNELS-1:0]                  out_rdy_i,
  output logic [NUM_CHANNELS-1:0][DATA_W-1:0]      out_data_o,
  output logic [NUM_CHANNELS-1:0][MSG_ID_SIZE-1:0] out_id_o,
  output logic [$clog2(TAG_DEPTH):0]               pending_o
);

  localparam int CHAN_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int TAG_AW  = $clog2(TAG_DEPTH);
  localparam int CHAN_AW = $clog2(CHAN_DEPTH);

  logic [MSG_ID_SIZE-1:0]  tag_mem [TAG_DEPTH];
  logic [TAG_AW-1:0]       tag_wptr, tag_rptr;
  logic [TAG_AW:0]         tag_cnt;
  logic                    tag_empty, tag_full, tag_push, tag_pop;
  logic [MSG_ID_SIZE-1:0]  tag_head;
  logic [CHAN_W-1:0]       sel;
  logic [NUM_CHANNELS-1:0] sel_oh, chan_full;
  logic                    in_accept;

  assign tag_empty = (tag_cnt == '0);
  assign tag_full  = (tag_cnt == (TAG_AW+1)'(TAG_DEPTH));
  assign tag_head  = tag_mem[tag_rptr];
  assign tag_rdy_o = !tag_full;
  assign tag_push  = tag_val_i && tag_rdy_o;
  assign pending_o = tag_cnt;

  generate
    if (NUM_CHANNELS == 1) begin : g_sel_single
      assign sel = '0;
    end else begin : g_sel_multi
      assign sel = tag_head[CHAN_W-1:0];
    end
  endgenerate

  always_comb begin
    sel_oh = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      sel_oh[c] = (sel == CHAN_W'(c));
    end
  end

  // Only the channel addressed by the head tag can back-pressure the core.
  assign in_rdy_o  = !tag_empty && !(|(chan_full & sel_oh));
  assign in_accept = in_val_i && in_rdy_o;
  assign tag_pop   = in_accept;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tag_wptr <= '0;
      tag_rptr <= '0;
      tag_cnt  <= '0;
    end else if (flush_i) begin
      tag_wptr <= '0;
      tag_rptr <= '0;
      tag_cnt  <= '0;
    end else begin
      if (tag_push) tag_wptr <= tag_wptr + 1'b1;
      if (tag_pop)  tag_rptr <= tag_rptr + 1'b1;
      if (tag_push && !tag_pop)      tag_cnt <= tag_cnt + 1'b1;
      else if (!tag_push && tag_pop) tag_cnt <= tag_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (tag_push) tag_mem[tag_wptr] <= tag_id_i;
  end

  generate
    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
      logic [DATA_W-1:0]      data_mem [CHAN_DEPTH];
      logic [MSG_ID_SIZE-1:0] id_mem   [CHAN_DEPTH];
      logic [CHAN_AW-1:0]     wptr, rptr;
      logic [CHAN_AW:0]       cnt;
      logic                   push, pop, val;

      assign val          = (cnt != '0);
      assign chan_full[c] = (cnt == (CHAN_AW+1)'(CHAN_DEPTH));
      assign push         = in_accept && sel_oh[c];
      assign pop          = val && out_rdy_i[c];
      assign out_val_o[c] = val;
      // Heads are gated so reset and empty channels present zeros.
      assign out_data_o[c] = val ? data_mem[rptr] : '0;
      assign out_id_o[c]   = val ? id_mem[rptr]   : '0;

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          wptr <= '0;
          rptr <= '0;
          cnt  <= '0;
        end else if (flush_i) begin
          wptr <= '0;
          rptr <= '0;
          cnt  <= '0;
        end else begin
          if (push) wptr <= wptr + 1'b1;
          if (pop)  rptr <= rptr + 1'b1;
          if (push && !pop)      cnt <= cnt + 1'b1;
          else if (!push && pop) cnt <= cnt - 1'b1;
        end
      end

      always_ff @(posedge clk_i) begin
        if (push) begin
          data_mem[wptr] <= in_data_i;
          id_mem[wptr]   <= tag_head;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_falafel_resp_router.sv
// Directed bench for falafel_resp_router: one task per scenario, inline checks.
module tb_falafel_resp_router;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic             flush_i;
  logic             tag_val_i;
  logic             tag_rdy_o;
  logic [7:0]       tag_id_i;
  logic             in_val_i;
  logic             in_rdy_o;
  logic [63:0]      in_data_i;
  logic [1:0]       out_val_o;
  logic [1:0]       out_rdy_i;
  logic [1:0][63:0] out_data_o;
  logic [1:0][7:0]  out_id_o;
  logic [3:0]       pending_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  q0_id[$], q1_id[$];
  logic [63:0] q0_d[$],  q1_d[$];

  falafel_resp_router #(
    .DATA_W(64), .MSG_ID_SIZE(8), .NUM_CHANNELS(2), .CHAN_DEPTH(4), .TAG_DEPTH(8)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .tag_val_i(tag_val_i), .tag_rdy_o(tag_rdy_o), .tag_id_i(tag_id_i),
    .in_val_i(in_val_i), .in_rdy_o(in_rdy_o), .in_data_i(in_data_i),
    .out_val_o(out_val_o), .out_rdy_i(out_rdy_i),
    .out_data_o(out_data_o), .out_id_o(out_id_o), .pending_o(pending_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    flush_i = 0; tag_val_i = 0; tag_id_i = 0;
    in_val_i = 0; in_data_i = 0; out_rdy_i = 0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_ni = 0;
    step();
    step();
    rst_ni = 1;
    step();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_ni = 0;
    step();
    n_checks++; if (out_val_o !== 2'b00) begin n_fail++; $display("FAIL reset_out_val: got %b want 00", out_val_o); end
    n_checks++; if (out_data_o !== '0) begin n_fail++; $display("FAIL reset_out_data: got %h want 0", out_data_o); end
    n_checks++; if (out_id_o !== '0) begin n_fail++; $display("FAIL reset_out_id: got %h want 0", out_id_o); end
    n_checks++; if (pending_o !== 4'd0) begin n_fail++; $display("FAIL reset_pending: got %0d want 0", pending_o); end
    n_checks++; if (in_rdy_o !== 1'b0) begin n_fail++; $display("FAIL reset_in_rdy: got %b want 0", in_rdy_o); end
    n_checks++; if (tag_rdy_o !== 1'b1) begin n_fail++; $display("FAIL reset_tag_rdy: got %b want 1", tag_rdy_o); end
    rst_ni = 1;
    step();
  endtask

  task automatic test_basic();
    apply_reset();
    tag_val_i = 1; tag_id_i = 8'h05;
    #1;
    n_checks++; if (in_rdy_o !== 1'b0) begin n_fail++; $display("FAIL basic_rdy_during_tag_write: got %b want 0", in_rdy_o); end
    step();
    tag_val_i = 0;
    n_checks++; if (in_rdy_o !== 1'b1) begin n_fail++; $display("FAIL basic_rdy_after_tag: got %b want 1", in_rdy_o); end
    n_checks++; if (pending_o !== 4'd1) begin n_fail++; $display("FAIL basic_pending: got %0d want 1", pending_o); end
    in_val_i = 1; in_data_i = 64'h1000;
    step();
    in_val_i = 0;
    n_checks++; if (out_val_o !== 2'b10) begin n_fail++; $display("FAIL basic_out_val: got %b want 10", out_val_o); end
    n_checks++; if (out_data_o[1] !== 64'h1000) begin n_fail++; $display("FAIL basic_data: got %h want 1000", out_data_o[1]); end
    n_checks++; if (out_id_o[1] !== 8'h05) begin n_fail++; $display("FAIL basic_id: got %h want 05", out_id_o[1]); end
    n_checks++; if (pending_o !== 4'd0) begin n_fail++; $display("FAIL basic_pending_after: got %0d want 0", pending_o); end
    step();
    n_checks++; if (out_val_o !== 2'b10) begin n_fail++; $display("FAIL basic_hold: got %b want 10", out_val_o); end
    out_rdy_i = 2'b10;
    step();
    out_rdy_i = 2'b00;
    n_checks++; if (out_val_o !== 2'b00) begin n_fail++; $display("FAIL basic_popped: got %b want 00", out_val_o); end
  endtask

  task automatic test_hol();
    logic [7:0] tags [6];
    int idx;
    logic acc;
    tags = '{8'd0, 8'd2, 8'd4, 8'd6, 8'd8, 8'd1};
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      tag_val_i = 1; tag_id_i = tags[i];
      step();
    end
    tag_val_i = 0;
    n_checks++; if (pending_o !== 4'd6) begin n_fail++; $display("FAIL hol_pending6: got %0d want 6", pending_o); end
    for (int i = 0; i < 4; i++) begin
      in_val_i = 1; in_data_i = 64'h100 + 64'(i);
      n_checks++; if (in_rdy_o !== 1'b1) begin n_fail++; $display("FAIL hol_accept%0d: got %b want 1", i, in_rdy_o); end
      step();
    end
    in_data_i = 64'h104;
    for (int i = 0; i < 2; i++) begin
      n_checks++; if (in_rdy_o !== 1'b0) begin n_fail++; $display("FAIL hol_stall%0d: got %b want 0", i, in_rdy_o); end
      step();
    end
    n_checks++; if (pending_o !== 4'd2) begin n_fail++; $display("FAIL hol_pending2: got %0d want 2", pending_o); end
    n_checks++; if (out_val_o !== 2'b01) begin n_fail++; $display("FAIL hol_val: got %b want 01", out_val_o); end
    q0_id.delete(); q0_d.delete(); q1_id.delete(); q1_d.delete();
    out_rdy_i = 2'b11;
    idx = 4;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (out_val_o[0] && out_rdy_i[0]) begin q0_id.push_back(out_id_o[0]); q0_d.push_back(out_data_o[0]); end
      if (out_val_o[1] && out_rdy_i[1]) begin q1_id.push_back(out_id_o[1]); q1_d.push_back(out_data_o[1]); end
      acc = in_val_i && in_rdy_o;
      step();
      if (acc) begin
        idx++;
        if (idx == 6) in_val_i = 0;
        else in_data_i = 64'h100 + 64'(idx);
      end
    end
    in_val_i = 0; out_rdy_i = 0;
    n_checks++; if (q0_id.size() != 5) begin n_fail++; $display("FAIL hol_ch0_count: got %0d want 5", q0_id.size()); end
    n_checks++; if (q1_id.size() != 1) begin n_fail++; $display("FAIL hol_ch1_count: got %0d want 1", q1_id.size()); end
    for (int i = 0; i < 5 && i < q0_id.size(); i++) begin
      n_checks++;
      if (q0_id[i] !== 8'(2*i) || q0_d[i] !== 64'h100 + 64'(i)) begin
        n_fail++; $display("FAIL hol_ch0_entry%0d: got id %h data %h want id %h data %h",
                           i, q0_id[i], q0_d[i], 8'(2*i), 64'h100 + 64'(i));
      end
    end
    if (q1_id.size() > 0) begin
      n_checks++;
      if (q1_id[0] !== 8'd1 || q1_d[0] !== 64'h105) begin
        n_fail++; $display("FAIL hol_ch1_entry: got id %h data %h want id 01 data 105", q1_id[0], q1_d[0]);
      end
    end
    n_checks++; if (pending_o !== 4'd0) begin n_fail++; $display("FAIL hol_pending_end: got %0d want 0", pending_o); end
  endtask

  task automatic test_tag_fifo();
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      tag_val_i = 1; tag_id_i = 8'h10 + 8'(i);
      step();
    end
    n_checks++; if (tag_rdy_o !== 1'b0) begin n_fail++; $display("FAIL tag_full_rdy: got %b want 0", tag_rdy_o); end
    n_checks++; if (pending_o !== 4'd8) begin n_fail++; $display("FAIL tag_full_pending: got %0d want 8", pending_o); end
    tag_id_i = 8'h55; in_val_i = 1; in_data_i = 64'h2000;
    n_checks++; if (in_rdy_o !== 1'b1) begin n_fail++; $display("FAIL tag_full_in_rdy: got %b want 1", in_rdy_o); end
    step();
    tag_val_i = 0; in_val_i = 0;
    n_checks++; if (pending_o !== 4'd7) begin n_fail++; $display("FAIL tag_pending7: got %0d want 7", pending_o); end
    n_checks++; if (tag_rdy_o !== 1'b1) begin n_fail++; $display("FAIL tag_rdy_after: got %b want 1", tag_rdy_o); end
    n_checks++; if (out_id_o[0] !== 8'h10 || out_data_o[0] !== 64'h2000) begin
      n_fail++; $display("FAIL tag_first_pair: got id %h data %h want id 10 data 2000", out_id_o[0], out_data_o[0]);
    end
  endtask

  task automatic test_no_tag();
    apply_reset();
    in_val_i = 1; in_data_i = 64'hABCD;
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (in_rdy_o !== 1'b0) begin n_fail++; $display("FAIL notag_rdy%0d: got %b want 0", i, in_rdy_o); end
      step();
    end
    n_checks++; if (out_val_o !== 2'b00) begin n_fail++; $display("FAIL notag_nothing_queued: got %b want 00", out_val_o); end
    tag_val_i = 1; tag_id_i = 8'h03;
    step();
    tag_val_i = 0;
    n_checks++; if (in_rdy_o !== 1'b1) begin n_fail++; $display("FAIL notag_rdy_after_tag: got %b want 1", in_rdy_o); end
    step();
    in_val_i = 0;
    n_checks++; if (out_val_o !== 2'b10 || out_data_o[1] !== 64'hABCD || out_id_o[1] !== 8'h03) begin
      n_fail++; $display("FAIL notag_result: got val %b data %h id %h want val 10 data abcd id 03",
                         out_val_o, out_data_o[1], out_id_o[1]);
    end
  endtask

  task automatic test_wrap();
    int tag_n, resp_n, cyc;
    logic tacc, racc, ch1_seen;
    apply_reset();
    q0_id.delete(); q0_d.delete();
    tag_n = 0; resp_n = 0; cyc = 0; ch1_seen = 0;
    tag_val_i = 1; tag_id_i = 8'd0;
    in_val_i = 1; in_data_i = 64'h3000;
    out_rdy_i = 2'b01;
    while (q0_id.size() < 20 && cyc < 300) begin
      if (out_val_o[0] && out_rdy_i[0]) begin q0_id.push_back(out_id_o[0]); q0_d.push_back(out_data_o[0]); end
      if (out_val_o[1]) ch1_seen = 1;
      tacc = tag_val_i && tag_rdy_o;
      racc = in_val_i && in_rdy_o;
      step();
      cyc++;
      if (tacc) tag_n++;
      if (racc) resp_n++;
      tag_val_i = (tag_n < 20); tag_id_i = 8'(2*tag_n);
      in_val_i = (resp_n < 20); in_data_i = 64'h3000 + 64'(resp_n);
      out_rdy_i[0] = ~out_rdy_i[0];
    end
    tag_val_i = 0; in_val_i = 0; out_rdy_i = 2'b00;
    n_checks++; if (q0_id.size() != 20) begin n_fail++; $display("FAIL wrap_count: got %0d want 20", q0_id.size()); end
    for (int i = 0; i < q0_id.size(); i++) begin
      n_checks++;
      if (q0_id[i] !== 8'(2*i) || q0_d[i] !== 64'h3000 + 64'(i)) begin
        n_fail++; $display("FAIL wrap_entry%0d: got id %h data %h want id %h data %h",
                           i, q0_id[i], q0_d[i], 8'(2*i), 64'h3000 + 64'(i));
      end
    end
    step();
    n_checks++; if (out_val_o !== 2'b00 || ch1_seen !== 1'b0) begin
      n_fail++; $display("FAIL wrap_no_extra: got val %b ch1_seen %b want 00 0", out_val_o, ch1_seen);
    end
    n_checks++; if (pending_o !== 4'd0) begin n_fail++; $display("FAIL wrap_pending: got %0d want 0", pending_o); end
  endtask

  task automatic test_flush_reset();
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      tag_val_i = 1; tag_id_i = 8'(i);
      step();
    end
    tag_val_i = 0;
    for (int i = 0; i < 3; i++) begin
      in_val_i = 1; in_data_i = 64'h500 + 64'(i);
      step();
    end
    in_val_i = 0;
    n_checks++; if (out_val_o !== 2'b11 || pending_o !== 4'd2) begin
      n_fail++; $display("FAIL flush_pre: got val %b pending %0d want 11 2", out_val_o, pending_o);
    end
    flush_i = 1; in_val_i = 1; in_data_i = 64'h5FF; tag_val_i = 1; tag_id_i = 8'h77; out_rdy_i = 2'b11;
    step();
    flush_i = 0; in_val_i = 0; tag_val_i = 0; out_rdy_i = 2'b00;
    n_checks++; if (out_val_o !== 2'b00 || pending_o !== 4'd0) begin
      n_fail++; $display("FAIL flush_post: got val %b pending %0d want 00 0", out_val_o, pending_o);
    end
    n_checks++; if (in_rdy_o !== 1'b0 || tag_rdy_o !== 1'b1) begin
      n_fail++; $display("FAIL flush_rdys: got in_rdy %b tag_rdy %b want 0 1", in_rdy_o, tag_rdy_o);
    end
    for (int i = 0; i < 3; i++) begin
      tag_val_i = 1; tag_id_i = 8'(i);
      step();
    end
    tag_val_i = 0;
    for (int i = 0; i < 2; i++) begin
      in_val_i = 1; in_data_i = 64'h600 + 64'(i);
      step();
    end
    in_val_i = 0;
    n_checks++; if (out_val_o !== 2'b11 || out_data_o[0] !== 64'h600 || out_data_o[1] !== 64'h601) begin
      n_fail++; $display("FAIL flush_refill: got val %b d0 %h d1 %h want 11 600 601", out_val_o, out_data_o[0], out_data_o[1]);
    end
    #3;
    rst_ni = 0;
    #1;
    n_checks++; if (out_val_o !== 2'b00 || pending_o !== 4'd0 || out_data_o !== '0) begin
      n_fail++; $display("FAIL async_reset: got val %b pending %0d data %h want 00 0 0", out_val_o, pending_o, out_data_o);
    end
    @(posedge clk_i); #1;
    rst_ni = 1;
    tag_val_i = 1; tag_id_i = 8'h07;
    step();
    tag_val_i = 0; in_val_i = 1; in_data_i = 64'h777;
    step();
    in_val_i = 0;
    n_checks++; if (out_val_o !== 2'b10 || out_id_o[1] !== 8'h07 || out_data_o[1] !== 64'h777) begin
      n_fail++; $display("FAIL post_reset_txn: got val %b id %h data %h want 10 07 777", out_val_o, out_id_o[1], out_data_o[1]);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hol();
    test_tag_fifo();
    test_no_tag();
    test_wrap();
    test_flush_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/falafel_resp_router.md
# falafel_resp_router

Multi-channel response router for the falafel allocator. Pairs each in-order allocation result from the core with the message ID captured when the matching alloc request left the alloc FIFO, and steers the tagged result to one of NUM_CHANNELS per-requester output queues. It replaces the single shared response FIFO and output FSM at the falafel top level, so one slow requester no longer blocks responses to the others.

## Interface
- DATA_W, 64, response data width (allocated pointer)
- MSG_ID_SIZE, 8, message ID width
- NUM_CHANNELS, 2, output channels; power of two, at least 1
- CHAN_DEPTH, 4, entries per channel FIFO; power of two, at least 2
- TAG_DEPTH, 8, entries in the pending-ID FIFO; power of two, at least 2
- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous, active-low
- flush_i  in  1  synchronous clear of all queues
- tag_val_i  in  1  ID push valid; driven when the core dequeues an alloc
- tag_rdy_o  out  1  pending-ID FIFO not full
- tag_id_i  in  MSG_ID_SIZE  ID of the dequeued alloc
- in_val_i  in  1  core response valid
- in_rdy_o  out  1  router accepts the response
- in_data_i  in  DATA_W  core response data
- out_val_o  out  NUM_CHANNELS  per-channel valid
- out_rdy_i  in  NUM_CHANNELS  per-channel ready
- out_data_o  out  NUM_CHANNELS x DATA_W  per-channel data
- out_id_o  out  NUM_CHANNELS x MSG_ID_SIZE  per-channel ID
- pending_o  out  $clog2(TAG_DEPTH)+1  IDs waiting for a response

## Operation
- Channel select: CHAN_W = max(1, $clog2(NUM_CHANNELS)). The channel is tag_head[CHAN_W-1:0]. With NUM_CHANNELS = 1, the channel is always 0.
- Tag push: happens when tag_val_i && tag_rdy_o. tag_rdy_o = !tag_full. There is no pop-through on a full FIFO.
- Response accept: in_rdy_o = !tag_empty && !chan_full[sel]. On in_val_i && in_rdy_o, the router pops the tag head and pushes {tag_head, in_data_i} into channel sel.
- No tag means no accept. in_rdy_o stays low while the pending-ID FIFO is empty, including the cycle in which the first tag is being written.
- Outputs: out_val_o[c] = !chan_empty[c]. out_data_o and out_id_o show the head of channel c. A pop happens on out_val_o[c] && out_rdy_i[c].
- Channels are independent. A full or stalled channel c blocks in_rdy_o only when the current head tag selects c.
- Per-channel ordering is preserved. Global order follows core response order.
- Simultaneous push and pop on a channel:
  - full: pop frees the slot, but in_rdy_o was already computed low, so there is no push;
  - empty: the push is visible next cycle, with no bypass.
- Simultaneous tag push and tag pop are allowed. The occupancy count is unchanged.
- pending_o holds the tag FIFO occupancy, 0..TAG_DEPTH.
- flush_i resets every read and write pointer and every count to empty. It overrides any push or pop in the same cycle. in_rdy_o and tag_rdy_o remain combinational from the current state.
- Pointer arithmetic: each FIFO keeps log2(depth)-bit pointers plus a separate count, so indices wrap naturally modulo depth.

## Timing
- Reset values, asynchronous assertion:
  - out_val_o = 0, out_data_o = 0, out_id_o = 0;
  - pending_o = 0, in_rdy_o = 0, tag_rdy_o = 1.
- Reset in the middle of operation discards every queued tag and response immediately.
- Latency:
  - tag written at cycle t can pair with a response from cycle t+1;
  - response accepted at cycle t shows out_val_o at t+1.
- Throughput: one response per cycle if tags are available and the target channel is not full.
- Valid/ready rules:
  - out_val_o and the out_data_o/out_id_o heads stay stable until popped or flushed;
  - in_rdy_o depends only on registered state, with no combinational path from in_val_i.

## Test plan
- Reset then idle: push tag 0x05, then respond 0x1000 a cycle later. Required: out_val_o[1] = 1 with data 0x1000 and ID 0x05 one cycle after accept; channel 0 stays silent.
- Head-of-line isolation, NUM_CHANNELS=2, CHAN_DEPTH=4, out_rdy_i[0] held low:
  - push tags 0,2,4,6,8,1;
  - send six responses;
  - required: the first four are accepted, the fifth stalls (in_rdy_o = 0), and after out_rdy_i[0] rises the remaining responses drain in order with IDs 8 then 1.
- Tag FIFO: push 8 tags without responses, so tag_rdy_o = 0 and pending_o = 8. Send one response with a tag push in the same cycle: the pushed tag is rejected and pending_o = 7. Next cycle, tag_rdy_o = 1.
- No-tag stall: with pending_o = 0, hold in_val_i high with 0xABCD. Required: in_rdy_o = 0 and nothing is queued. Push tag 0x03; the response is accepted one cycle later and appears on channel 1.
- Wrap-around: stream 20 responses through channel 0 with out_rdy_i toggling every cycle. Required: all 20 arrive in order with matching IDs and no loss or duplicates.
- Flush and reset: queue 3 responses and 2 tags. Assert flush_i for one cycle; required next cycle: every out_val_o = 0 and pending_o = 0. Repeat with rst_ni low mid-burst; outputs clear without waiting for a clock edge.
